// File: rtl/riscv_mem_pkg.sv
// Shared types and address checking for the load/store memory responder.
package riscv_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    // True when addr is not word aligned or falls outside [base, base+span).
    function automatic logic addr_err(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [32:0] span);
        return (addr[1:0] != 2'b00) || (addr < base) ||
               ({1'b0, addr} >= ({1'b0, base} + span));
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Synchronous word RAM with per-byte write enables; read data registered.
module mem_word_array
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Load/store responder: accepts one request, inserts wait states, then returns
// read data or a write acknowledge over a valid/ready response channel.
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam logic [32:0] SPAN  = 33'(DEPTH) * 33'(WORD_BYTES);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    mem_req_t         lat, lat_d, cur_c, acc_c;
    logic             pend, pend_d;
    logic             err_q, err_d;
    logic             req_ready_d, rsp_valid_d, rsp_err_d;
    logic [31:0]      rsp_rdata_d, ram_rdata;
    logic             accept_c, enter_c, acc_err_c, ram_en_c;
    logic [IDX_W-1:0] ram_idx_c;

    // With zero wait states the RAM is accessed on the accept edge, so the
    // live request is used there; otherwise the latched copy.
    always_comb begin
        cur_c.we    = req_we;
        cur_c.addr  = req_addr;
        cur_c.wdata = req_wdata;
        cur_c.be    = req_be;
        acc_c       = (state == IDLE) ? cur_c : lat;
        accept_c    = (state == IDLE) && req_ready && req_valid;
        enter_c     = (accept_c && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == '0));
        acc_err_c   = addr_err(acc_c.addr, ADDR_BASE, SPAN);
        ram_en_c    = enter_c && !acc_err_c;
        ram_idx_c   = IDX_W'((acc_c.addr - ADDR_BASE) >> 2);
    end

    mem_word_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (acc_c.we),
        .be    (acc_c.be),
        .idx   (ram_idx_c),
        .wdata (acc_c.wdata),
        .rdata (ram_rdata)
    );

    // Next-state and next-output logic; pend marks the RESP cycle spent
    // waiting for the RAM's registered read data.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        lat_d       = lat;
        pend_d      = pend;
        err_d       = err_q;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        if (enter_c) begin
            err_d  = acc_err_c;
            pend_d = 1'b1;
        end
        case (state)
            IDLE: begin
                req_ready_d = 1'b1;
                if (accept_c) begin
                    lat_d       = cur_c;
                    req_ready_d = 1'b0;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) state_d = RESP;
                else           cnt_d   = cnt - 1'b1;
            end
            RESP: begin
                if (pend) begin
                    pend_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (err_q || lat.we) ? 32'h0 : ram_rdata;
                end else if (rsp_valid && rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat       <= '0;
            pend      <= 1'b0;
            err_q     <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            lat       <= lat_d;
            pend      <= pend_d;
            err_q     <= err_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Bench for riscv_mem_responder: three instances (2, 0 and 15 wait states)
// checked every cycle against a transaction-level model, plus directed literals.
module tb_riscv_mem_responder;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    riscv_mem_responder #(.DEPTH(DEPTH), .ADDR_BASE(32'h0000_0000), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
    riscv_mem_responder #(.DEPTH(DEPTH), .ADDR_BASE(32'h0000_1000), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
    riscv_mem_responder #(.DEPTH(DEPTH), .ADDR_BASE(32'h8000_0000), .WAIT_CYCLES(15)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    function automatic int wc(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    function automatic logic [31:0] base(input int k);
        case (k)
            0:       return 32'h0000_0000;
            1:       return 32'h0000_1000;
            default: return 32'h8000_0000;
        endcase
    endfunction

    function automatic logic [31:0] fillv(input int k, input int i);
        return {8'hA5, 8'(k), 8'h00, 8'(i)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Transaction-level model: idle/busy per instance, age in edges since acceptance.
    bit          m_busy  [3];
    int          m_age   [3];
    logic        m_ready [3];
    logic        m_valid [3];
    logic [31:0] m_rd    [3];
    logic        m_err   [3];
    logic        p_we    [3];
    logic [31:0] p_addr  [3];
    logic [31:0] p_wd    [3];
    logic [3:0]  p_be    [3];
    logic [31:0] mem_m   [3][DEPTH];

    function automatic void resolve(input int k);
        longint d;
        int     idx;
        bit     e;
        d   = longint'({32'h0, p_addr[k]}) - longint'({32'h0, base(k)});
        e   = (p_addr[k][1:0] != 2'b00) || (d < 0) || (d >= longint'(DEPTH * 4));
        idx = e ? 0 : int'(d / 4);
        if (!e && p_we[k])
            for (int b = 0; b < 4; b++)
                if (p_be[k][b]) mem_m[k][idx][8*b +: 8] = p_wd[k][8*b +: 8];
        m_err[k] = e;
        m_rd[k]  = (e || p_we[k]) ? 32'h0 : mem_m[k][idx];
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                m_busy[k] = 1'b0; m_ready[k] = 1'b0; m_valid[k] = 1'b0; m_age[k] = 0;
            end else if (!m_busy[k]) begin
                if (req_valid[k] && m_ready[k]) begin
                    m_busy[k] = 1'b1; m_age[k] = 0; m_ready[k] = 1'b0;
                    p_we[k] = req_we[k]; p_addr[k] = req_addr[k];
                    p_wd[k] = req_wdata[k]; p_be[k] = req_be[k];
                    if (wc(k) == 0) resolve(k);
                end else begin
                    m_ready[k] = 1'b1;
                end
            end else begin
                m_age[k]++;
                if (m_valid[k] && rsp_ready[k]) begin
                    m_busy[k] = 1'b0; m_valid[k] = 1'b0; m_ready[k] = 1'b1;
                end else begin
                    if (m_age[k] == wc(k)) resolve(k);
                    if (m_age[k] == wc(k) + 1) m_valid[k] = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Every-cycle comparison of all outputs against the model.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d_req_ready", k), 32'(req_ready[k]), 32'(m_ready[k]));
            chk($sformatf("d%0d_rsp_valid", k), 32'(rsp_valid[k]), 32'(m_valid[k]));
            chk($sformatf("d%0d_rsp_rdata", k), rsp_rdata[k], m_valid[k] ? m_rd[k] : 32'h0);
            chk($sformatf("d%0d_rsp_err", k), 32'(rsp_err[k]), m_valid[k] ? 32'(m_err[k]) : 32'h0);
        end
    end

    task automatic txn(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold, input string tag,
                       output logic [31:0] rd, output logic er, output int lat);
        int t0;
        bit ok;
        rd = 32'h0; er = 1'b0; lat = -1;
        @(negedge clk);
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wd; req_be[k] = be;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready[k]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk({tag, "_accept_timeout"}, 32'(ok), 32'h1);
        if (!ok) begin req_valid[k] = 1'b0; return; end
        @(negedge clk);
        t0 = cyc;
        req_valid[k] = 1'b0; req_we[k] = 1'($urandom); req_addr[k] = $urandom;
        req_wdata[k] = $urandom; req_be[k] = 4'($urandom); rsp_ready[k] = 1'($urandom);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid[k]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk({tag, "_rsp_timeout"}, 32'(ok), 32'h1);
        if (!ok) return;
        lat = cyc - t0;
        rd = rsp_rdata[k]; er = rsp_err[k];
        rsp_ready[k] = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(rsp_valid[k]), 32'h1);
            chk({tag, "_hold_rdata"}, rsp_rdata[k], rd);
            chk({tag, "_hold_err"}, 32'(rsp_err[k]), 32'(er));
            chk({tag, "_hold_req_ready"}, 32'(req_ready[k]), 32'h0);
        end
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        chk({tag, "_done_valid"}, 32'(rsp_valid[k]), 32'h0);
        chk({tag, "_done_req_ready"}, 32'(req_ready[k]), 32'h1);
        rsp_ready[k] = 1'($urandom);
    endtask

    task automatic b2b(input int k, input int period);
        int  acc[$];
        bit  ok;
        @(negedge clk);
        rsp_ready[k] = 1'b1; req_valid[k] = 1'b1; req_we[k] = 1'b0;
        req_addr[k] = base(k) + 32'h8; req_be[k] = 4'hF;
        for (int i = 0; i < 4 * period + 4; i++) begin
            if (req_ready[k]) acc.push_back(cyc + 1);
            @(negedge clk);
        end
        req_valid[k] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (req_ready[k] && !rsp_valid[k]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk($sformatf("d%0d_b2b_drain", k), 32'(ok), 32'h1);
        chk($sformatf("d%0d_b2b_count", k), 32'(acc.size() >= 3), 32'h1);
        for (int i = 1; i < acc.size(); i++)
            chk($sformatf("d%0d_b2b_period", k), 32'(acc[i] - acc[i-1]), 32'(period));
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          off;
    logic [31:0] a;
    bit          ok;

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 32'h0;
            req_wdata[k] = 32'h0; req_be[k] = 4'h0; rsp_ready[k] = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_req_ready", 32'(req_ready[k]), 32'h0);
            chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'h0);
            chk("reset_rsp_rdata", rsp_rdata[k], 32'h0);
            chk("reset_rsp_err", 32'(rsp_err[k]), 32'h0);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1 chk("post_reset_ready_low", 32'(req_ready[0]), 32'h0);
        @(negedge clk);
        chk("post_reset_ready_high", 32'(req_ready[0]), 32'h1);

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < DEPTH; i++)
                txn(k, 1'b1, base(k) + 32'(4 * i), fillv(k, i), 4'hF, 0, "fill", rd, er, lat);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st10", rd, er, lat);
        chk("st10_lat", 32'(lat), 32'd3);
        chk("st10_err", 32'(er), 32'h0);
        chk("st10_rdata", rd, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, "ld10", rd, er, lat);
        chk("ld10_rdata", rd, 32'hDEADBEEF);
        chk("ld10_lat", 32'(lat), 32'd3);

        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1, "st20", rd, er, lat);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 2, "st20be", rd, er, lat);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "ld20", rd, er, lat);
        chk("ld20_merged", rd, 32'h11BB33DD);
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, "st20be0", rd, er, lat);
        chk("st20be0_err", 32'(er), 32'h0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "ld20b", rd, er, lat);
        chk("ld20_after_be0", rd, 32'h11BB33DD);

        txn(0, 1'b0, 32'h13, 32'h0, 4'hF, 0, "ld13", rd, er, lat);
        chk("ld13_err", 32'(er), 32'h1);
        chk("ld13_rdata", rd, 32'h0);
        chk("ld13_lat", 32'(lat), 32'd3);
        txn(0, 1'b1, 32'h80, 32'h55555555, 4'hF, 0, "st_oor", rd, er, lat);
        chk("st_oor_err", 32'(er), 32'h1);
        txn(0, 1'b0, 32'h7C, 32'h0, 4'h0, 0, "ld_top", rd, er, lat);
        chk("ld_top_unchanged", rd, 32'hA500001F);
        chk("ld_top_err", 32'(er), 32'h0);

        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, "bp", rd, er, lat);
        chk("bp_rdata", rd, 32'hDEADBEEF);

        txn(1, 1'b1, 32'h1004, 32'hCAFEF00D, 4'hF, 0, "w0_st", rd, er, lat);
        chk("w0_lat", 32'(lat), 32'd1);
        txn(1, 1'b0, 32'h1004, 32'h0, 4'h0, 0, "w0_ld", rd, er, lat);
        chk("w0_ld_rdata", rd, 32'hCAFEF00D);
        txn(1, 1'b0, 32'h0FFC, 32'h0, 4'h0, 0, "w0_below", rd, er, lat);
        chk("w0_below_err", 32'(er), 32'h1);
        txn(2, 1'b0, 32'h8000_000C, 32'h0, 4'h0, 0, "w15_ld", rd, er, lat);
        chk("w15_lat", 32'(lat), 32'd16);
        chk("w15_rdata", rd, 32'hA5020003);

        b2b(0, 5);
        b2b(1, 3);
        b2b(2, 18);

        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h40;
        req_wdata[0] = 32'h12345678; req_be[0] = 4'hF; rsp_ready[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready[0]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("rstmid_accept_timeout", 32'(ok), 32'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rstmid_req_ready", 32'(req_ready[0]), 32'h0);
        chk("rstmid_rsp_valid", 32'(rsp_valid[0]), 32'h0);
        chk("rstmid_rsp_rdata", rsp_rdata[0], 32'h0);
        chk("rstmid_rsp_err", 32'(rsp_err[0]), 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, "rstmid_ld", rd, er, lat);
        chk("rstmid_old_value", rd, 32'hA5000010);

        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 40; n++) begin
                off = int'($urandom_range(0, DEPTH * 4 + 15)) - 8;
                a   = base(k) + 32'(off);
                a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
                txn(k, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                    "rnd", rd, er, lat);
                chk("rnd_lat", 32'(lat), 32'(wc(k) + 1));
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    req_valid[k] = 1'b0; req_addr[k] = $urandom; req_we[k] = 1'($urandom);
                    req_wdata[k] = $urandom; rsp_ready[k] = 1'($urandom);
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
